// File: rtl/sa_pkg.sv
// Shared definitions for the weight-stationary systolic array: mode encoding,
// saturation limits and a generic signed clamp.
package sa_pkg;

    localparam logic MODE_PRELOAD = 1'b0;
    localparam logic MODE_COMPUTE = 1'b1;

    // Limits are returned as longint so one helper serves every width up to 63 bits.
    function automatic longint sat_min(input int width);
        return -(64'sd1 <<< (width - 1));
    endfunction

    function automatic longint sat_max(input int width);
        return (64'sd1 <<< (width - 1)) - 64'sd1;
    endfunction

    function automatic longint sat_clamp(input longint value, input longint lo, input longint hi);
        if (value < lo) begin
            return lo;
        end else if (value > hi) begin
            return hi;
        end
        return value;
    endfunction

endpackage

// File: rtl/sa_mac.sv
// Combinational signed MAC with saturation of the product and of the sum;
// the result never wraps.
module sa_mac
    import sa_pkg::*;
#(
    parameter int MUL_DATAWIDTH = 8,
    parameter int ADD_DATAWIDTH = 8
) (
    input  logic signed [MUL_DATAWIDTH-1:0] act,
    input  logic signed [MUL_DATAWIDTH-1:0] weight,
    input  logic signed [ADD_DATAWIDTH-1:0] psum,
    output logic signed [ADD_DATAWIDTH-1:0] o_psum
);

    localparam longint MIN_ADD = sat_min(ADD_DATAWIDTH);
    localparam longint MAX_ADD = sat_max(ADD_DATAWIDTH);

    logic signed [2*MUL_DATAWIDTH-1:0] product;
    logic signed [ADD_DATAWIDTH-1:0]   mult_result_sat;
    logic signed [ADD_DATAWIDTH:0]     sum;

    assign product = act * weight;

    // Clamping the product before the add keeps a huge product from masking psum.
    assign mult_result_sat = ADD_DATAWIDTH'(sat_clamp(longint'(product), MIN_ADD, MAX_ADD));

    assign sum    = (ADD_DATAWIDTH + 1)'(mult_result_sat) + (ADD_DATAWIDTH + 1)'(psum);
    assign o_psum = ADD_DATAWIDTH'(sat_clamp(longint'(sum), MIN_ADD, MAX_ADD));

endmodule

// File: rtl/sa_processing_element.sv
// Weight-stationary systolic PE: holds the stationary weight, forwards the
// activation east and the preload weight or saturated MAC result south.
module sa_processing_element
    import sa_pkg::*;
#(
    parameter int MUL_DATAWIDTH = 8,
    parameter int ADD_DATAWIDTH = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            i_mode,
    input  logic signed [MUL_DATAWIDTH-1:0] i_act,
    input  logic signed [MUL_DATAWIDTH-1:0] i_weight,
    input  logic signed [ADD_DATAWIDTH-1:0] i_psum,
    output logic signed [MUL_DATAWIDTH-1:0] o_act,
    output logic signed [ADD_DATAWIDTH-1:0] o_weight_psum
);

    // No handshake: every cycle carries valid data and is consumed on the next edge.
    // rst_n is active-high despite its name so the PE tiles with existing arrays.

    logic signed [MUL_DATAWIDTH-1:0] weight_q;
    logic signed [ADD_DATAWIDTH-1:0] mac_result;

    sa_mac #(
        .MUL_DATAWIDTH(MUL_DATAWIDTH),
        .ADD_DATAWIDTH(ADD_DATAWIDTH)
    ) sa_mac_0 (
        .act   (i_act),
        .weight(weight_q),
        .psum  (i_psum),
        .o_psum(mac_result)
    );

    always_ff @(posedge clk) begin
        if (rst_n) begin
            weight_q      <= '0;
            o_act         <= '0;
            o_weight_psum <= '0;
        end else if (i_mode == MODE_PRELOAD) begin
            weight_q      <= i_weight;
            o_weight_psum <= ADD_DATAWIDTH'(i_weight);
        end else begin
            o_act         <= i_act;
            o_weight_psum <= mac_result;
        end
    end

endmodule

// File: tb/tb_sa_processing_element.sv
// Directed test of sa_processing_element (8/8): reset, MAC, saturation,
// preload pass-through and weight stationarity.
module tb_sa_processing_element;

    logic              clk;
    logic              rst_n;
    logic              i_mode;
    logic signed [7:0] i_act;
    logic signed [7:0] i_weight;
    logic signed [7:0] i_psum;
    logic signed [7:0] o_act;
    logic signed [7:0] o_weight_psum;

    int checks;
    int errors;

    sa_processing_element #(
        .MUL_DATAWIDTH(8),
        .ADD_DATAWIDTH(8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_mode       (i_mode),
        .i_act        (i_act),
        .i_weight     (i_weight),
        .i_psum       (i_psum),
        .o_act        (o_act),
        .o_weight_psum(o_weight_psum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply inputs, then move to 1 time unit past the next rising edge.
    task automatic drive(input logic rst, input logic mode, input logic signed [7:0] act,
                         input logic signed [7:0] weight, input logic signed [7:0] psum);
        rst_n    = rst;
        i_mode   = mode;
        i_act    = act;
        i_weight = weight;
        i_psum   = psum;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom));
            checks++;
            if (o_act !== 8'sd0 || o_weight_psum !== 8'sd0) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: o_act=%0d o_weight_psum=%0d, required 0 and 0",
                         i, o_act, o_weight_psum);
            end
        end
        drive(1'b0, 1'b1, 8'sd0, 8'sd0, 8'sd0);
        checks++;
        if (o_act !== 8'sd0 || o_weight_psum !== 8'sd0) begin
            errors++;
            $display("FAIL reset_after: o_act=%0d o_weight_psum=%0d, required 0 and 0", o_act, o_weight_psum);
        end
        // Weight must have been cleared: 5 * 0 + 0 = 0
        drive(1'b0, 1'b1, 8'sd5, 8'sd77, 8'sd0);
        checks++;
        if (o_act !== 8'sd5 || o_weight_psum !== 8'sd0) begin
            errors++;
            $display("FAIL reset_weight_zero: o_act=%0d o_weight_psum=%0d, required 5 and 0", o_act, o_weight_psum);
        end
    endtask

    task automatic test_basic_mac();
        drive(1'b0, 1'b0, 8'sd99, -8'sd1, 8'sd0);
        checks++;
        if (o_act !== 8'sd5 || o_weight_psum !== -8'sd1) begin
            errors++;
            $display("FAIL basic_preload: o_act=%0d o_weight_psum=%0d, required 5 and -1", o_act, o_weight_psum);
        end
        drive(1'b0, 1'b1, 8'sd7, 8'sd33, 8'sd127);
        checks++;
        if (o_act !== 8'sd7 || o_weight_psum !== 8'sd120) begin
            errors++;
            $display("FAIL basic_mac: o_act=%0d o_weight_psum=%0d, required 7 and 120", o_act, o_weight_psum);
        end
    endtask

    task automatic test_sat_positive();
        drive(1'b0, 1'b0, 8'sd0, 8'sd127, 8'sd0);
        drive(1'b0, 1'b1, 8'sd127, 8'sd0, 8'sd0);
        checks++;
        if (o_weight_psum !== 8'sd127) begin
            errors++;
            $display("FAIL sat_pos_psum0: o_weight_psum=%0d, required 127", o_weight_psum);
        end
        drive(1'b0, 1'b1, 8'sd127, 8'sd0, 8'sd127);
        checks++;
        if (o_weight_psum !== 8'sd127) begin
            errors++;
            $display("FAIL sat_pos_psum127: o_weight_psum=%0d, required 127", o_weight_psum);
        end
        // Product clamps to 127 before the add: 127 + (-128) = -1
        drive(1'b0, 1'b1, 8'sd127, 8'sd0, -8'sd128);
        checks++;
        if (o_weight_psum !== -8'sd1) begin
            errors++;
            $display("FAIL sat_pos_clamp_then_add: o_weight_psum=%0d, required -1", o_weight_psum);
        end
    endtask

    task automatic test_sat_negative();
        drive(1'b0, 1'b0, 8'sd0, -8'sd128, 8'sd0);
        drive(1'b0, 1'b1, 8'sd127, 8'sd0, -8'sd128);
        checks++;
        if (o_weight_psum !== -8'sd128) begin
            errors++;
            $display("FAIL sat_neg: o_weight_psum=%0d, required -128", o_weight_psum);
        end
        drive(1'b0, 1'b1, 8'sd127, 8'sd0, 8'sd127);
        checks++;
        if (o_weight_psum !== -8'sd1) begin
            errors++;
            $display("FAIL sat_neg_clamp_then_add: o_weight_psum=%0d, required -1", o_weight_psum);
        end
        // (-128) * (-128) = 16384 clamps to 127; 127 + (-1) = 126
        drive(1'b0, 1'b1, -8'sd128, 8'sd0, -8'sd1);
        checks++;
        if (o_act !== -8'sd128 || o_weight_psum !== 8'sd126) begin
            errors++;
            $display("FAIL sat_neg_squared: o_act=%0d o_weight_psum=%0d, required -128 and 126", o_act, o_weight_psum);
        end
    endtask

    task automatic test_preload_passthrough();
        logic signed [7:0] weights [3];
        weights[0] = 8'sd5;
        weights[1] = -8'sd3;
        weights[2] = 8'sd100;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 8'($urandom), weights[i], 8'($urandom));
            checks++;
            if (o_weight_psum !== weights[i] || o_act !== -8'sd128) begin
                errors++;
                $display("FAIL preload_pass %0d: o_weight_psum=%0d o_act=%0d, required %0d and -128",
                         i, o_weight_psum, o_act, weights[i]);
            end
        end
    endtask

    task automatic test_back_to_back_stationary();
        logic signed [7:0] exp_v;
        drive(1'b0, 1'b0, 8'sd0, 8'sd2, 8'sd0);
        for (int a = 1; a <= 4; a++) begin
            drive(1'b0, 1'b1, 8'(a), 8'($urandom), 8'sd10);
            exp_v = 8'(10 + 2 * a);
            checks++;
            if (o_weight_psum !== exp_v || o_act !== 8'(a)) begin
                errors++;
                $display("FAIL stationary act=%0d: o_weight_psum=%0d o_act=%0d, required %0d and %0d",
                         a, o_weight_psum, o_act, exp_v, a);
            end
        end
    endtask

    task automatic test_reset_priority();
        drive(1'b1, 1'b0, 8'sd9, 8'sd50, 8'sd0);
        checks++;
        if (o_act !== 8'sd0 || o_weight_psum !== 8'sd0) begin
            errors++;
            $display("FAIL reset_priority: o_act=%0d o_weight_psum=%0d, required 0 and 0", o_act, o_weight_psum);
        end
        drive(1'b0, 1'b1, 8'sd3, 8'sd0, 8'sd4);
        checks++;
        if (o_act !== 8'sd3 || o_weight_psum !== 8'sd4) begin
            errors++;
            $display("FAIL post_reset_weight0: o_act=%0d o_weight_psum=%0d, required 3 and 4", o_act, o_weight_psum);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b1;
        i_mode   = 1'b0;
        i_act    = '0;
        i_weight = '0;
        i_psum   = '0;
        test_reset();
        test_basic_mac();
        test_sat_positive();
        test_sat_negative();
        test_preload_passthrough();
        test_back_to_back_stationary();
        test_reset_priority();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
